// File: rtl/mem_pkg.sv
// Shared constants and types for the RAM scan/clear reader.
//   MEM_DEPTH / MEM_ADDR_W : geometry of the Kx1024 synchronous RAM
//   scan_state_t           : reader FSM states
package mem_pkg;

    localparam int unsigned MEM_DEPTH  = 1024;
    localparam int unsigned MEM_ADDR_W = 10;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        SCAN,
        DRAIN
    } scan_state_t;

endpackage

// File: rtl/mem_rd_skid.sv
// Two-entry FIFO holding {data, last} for words read back from the RAM.
// Push and pop in the same cycle are legal. The head entry is held in a register,
// so pop_data/pop_last stay stable while the consumer stalls.
//   clk, rst_n           clock, asynchronous active-low reset
//   push, push_data/last write one entry
//   pop                  remove the head entry (only when not empty)
//   pop_data/last        head entry
//   count, full, empty   occupancy
module mem_rd_skid #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              push_last,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_last,
    output logic [1:0]        count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] data_q [2];
    logic              last_q [2];
    logic              wr_idx_q, rd_idx_q;
    logic [1:0]        count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q[0] <= '0;
            data_q[1] <= '0;
            last_q[0] <= 1'b0;
            last_q[1] <= 1'b0;
            wr_idx_q  <= 1'b0;
            rd_idx_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            if (push) begin
                data_q[wr_idx_q] <= push_data;
                last_q[wr_idx_q] <= push_last;
                wr_idx_q         <= ~wr_idx_q;
            end
            if (pop) begin
                rd_idx_q <= ~rd_idx_q;
            end
            count_q <= count_d;
        end
    end

    assign pop_data = data_q[rd_idx_q];
    assign pop_last = last_q[rd_idx_q];
    assign count    = count_q;
    assign full     = (count_q == 2'd2);
    assign empty    = (count_q == 2'd0);

endmodule

// File: rtl/mem_scan_reader.sv
// Reader/initiator for a Kx1024 synchronous RAM (registered 1-cycle read, sync write).
// Streams addresses 0..len-1 out as a valid/ready stream, or writes CLEAR_VAL to every word.
//   clk, rst_n                 clock shared with the RAM, asynchronous active-low reset
//   start_scan, len            scan request and length (clamped to DEPTH)
//   start_clear                clear request (wins over start_scan)
//   mem_wr/addr/d_i, mem_d_o   RAM interface
//   out_valid/ready/data/last  output stream, out_last on the word from addr len-1
//   busy, done                 not idle; 1-cycle completion pulse
module mem_scan_reader
    import mem_pkg::*;
#(
    parameter int unsigned       DATA_W    = 8,
    parameter int unsigned       ADDR_W    = MEM_ADDR_W,
    parameter int unsigned       DEPTH     = MEM_DEPTH,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_scan,
    input  logic              start_clear,
    input  logic [ADDR_W:0]   len,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_d_i,
    input  logic [DATA_W-1:0] mem_d_o,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W:0] DepthL   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LastAddr = DepthL - 1'b1;

    scan_state_t       state_q, state_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic              inflight_q, inflight_last_q, issue_last;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] addr_hold_q;

    logic              issue, pop;
    logic [1:0]        fifo_count;
    logic              fifo_full, fifo_empty;
    logic [2:0]        credit;

    assign out_valid = ~fifo_empty;
    assign pop       = out_valid & out_ready;
    // Words already committed to the FIFO once the current pop and the read in flight settle.
    assign credit    = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};

    always_comb begin
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        len_d      = len_q;
        done_d     = 1'b0;
        issue      = 1'b0;
        issue_last = 1'b0;
        mem_wr     = 1'b0;
        mem_d_i    = '0;
        mem_addr   = addr_hold_q;
        case (state_q)
            IDLE: begin
                if (start_clear) begin
                    state_d  = CLEAR;
                    rd_ptr_d = '0;
                end else if (start_scan) begin
                    if (len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d  = SCAN;
                        rd_ptr_d = '0;
                        len_d    = (len > DepthL) ? DepthL : len;
                    end
                end
            end
            CLEAR: begin
                mem_wr   = 1'b1;
                mem_d_i  = CLEAR_VAL;
                mem_addr = rd_ptr_q[ADDR_W-1:0];
                rd_ptr_d = rd_ptr_q + 1'b1;
                if (rd_ptr_q == LastAddr) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            SCAN: begin
                mem_addr = rd_ptr_q[ADDR_W-1:0];
                if (credit < 3'd2) begin
                    issue    = 1'b1;
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    if (rd_ptr_q == len_q - 1'b1) begin
                        issue_last = 1'b1;
                        state_d    = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && out_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            rd_ptr_q        <= '0;
            len_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
            addr_hold_q     <= '0;
        end else begin
            state_q         <= state_d;
            rd_ptr_q        <= rd_ptr_d;
            len_q           <= len_d;
            inflight_q      <= issue;
            inflight_last_q <= issue_last;
            done_q          <= done_d;
            addr_hold_q     <= mem_addr;
        end
    end

    // Read data appears on mem_d_o the cycle after its address was issued.
    mem_rd_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_q),
        .push_data (mem_d_o),
        .push_last (inflight_last_q),
        .pop       (pop),
        .pop_data  (out_data),
        .pop_last  (out_last),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign busy = (state_q != IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_mem_scan_reader.sv
module tb_mem_scan_reader;

    localparam int DW    = 8;
    localparam int AW    = 10;
    localparam int DEPTH = 1024;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_scan = 1'b0;
    logic          start_clear = 1'b0;
    logic [AW:0]   len = '0;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_d_i;
    logic [DW-1:0] mem_d_o = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    mem_scan_reader #(
        .DATA_W    (DW),
        .ADDR_W    (AW),
        .DEPTH     (DEPTH),
        .CLEAR_VAL (8'h00)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_scan  (start_scan),
        .start_clear (start_clear),
        .len         (len),
        .mem_wr      (mem_wr),
        .mem_addr    (mem_addr),
        .mem_d_i     (mem_d_i),
        .mem_d_o     (mem_d_o),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done)
    );

    // RAM model: sync write, registered read. preload_req 1 -> addr[7:0], 2 -> addr[7:0]^8'h5A.
    logic [DW-1:0] ram [DEPTH];
    logic [1:0]    preload_req = 2'd0;

    always @(posedge clk) begin
        if (preload_req != 2'd0) begin
            for (int i = 0; i < DEPTH; i++) begin
                ram[i] <= (preload_req == 2'd1) ? 8'(i) : (8'(i) ^ 8'h5A);
            end
        end else if (mem_wr) begin
            ram[mem_addr] <= mem_d_i;
        end
        mem_d_o <= ram[mem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Downstream ready: constant 1, or the repeating pattern 1,0,0,1.
    logic       rdy_mode = 1'b0;
    logic [3:0] rdy_pat  = 4'b1001;
    int         rdy_k    = 0;
    always @(posedge clk) begin
        #1;
        if (rdy_mode) begin
            out_ready = rdy_pat[rdy_k];
            rdy_k     = (rdy_k + 1) % 4;
        end else begin
            out_ready = 1'b1;
        end
    end

    // Stream monitor, sampled at the falling edge.
    int            t0 = 0;
    int            beats, data_err, last_err, gaps, stall_err, wr_cnt, wr_bad;
    int            first_valid, done_cnt, done_rel, exp_len, exp_mode;
    bit            got_last, prev_stall;
    logic [DW-1:0] prev_data, exp_d;
    logic          prev_last;

    always @(negedge clk) begin
        if (mem_wr) begin
            wr_cnt++;
            if (mem_d_i !== 8'h00) wr_bad++;
        end
        if (prev_stall && (!out_valid || out_data !== prev_data || out_last !== prev_last))
            stall_err++;
        if (out_valid && first_valid < 0) first_valid = cyc - t0;
        if (first_valid >= 0 && !got_last && !out_valid) gaps++;
        if (out_valid && out_ready) begin
            exp_d = (exp_mode != 0) ? 8'(beats) : 8'h00;
            if (out_data !== exp_d) data_err++;
            if (out_last !== (beats == exp_len - 1)) last_err++;
            if (out_last) got_last = 1'b1;
            beats++;
        end
        if (done) begin
            done_cnt++;
            done_rel = cyc - t0;
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
    end

    int tests  = 0;
    int failed = 0;

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got != exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic mon_reset(input int l, input int mode);
        beats = 0; data_err = 0; last_err = 0; gaps = 0; stall_err = 0;
        wr_cnt = 0; wr_bad = 0; first_valid = -1; done_cnt = 0; done_rel = -1;
        got_last = 1'b0; prev_stall = 1'b0; exp_len = l; exp_mode = mode;
    endtask

    task automatic preload(input logic [1:0] mode);
        @(posedge clk); #1;
        preload_req = mode;
        @(posedge clk); #1;
        preload_req = 2'd0;
    endtask

    task automatic pulse(input bit sc, input bit cl, input int l);
        @(posedge clk); #1;
        start_scan  = sc;
        start_clear = cl;
        len         = (AW + 1)'(l);
        t0          = cyc;
        @(posedge clk); #1;
        start_scan  = 1'b0;
        start_clear = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(posedge clk); #2;
            n++;
        end
        if (done_cnt == 0) check({tag, "_timeout"}, 0, 1);
        repeat (4) @(posedge clk);
        #2;
    endtask

    function automatic int ram_nonzero();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) if (ram[i] != 8'h00) n++;
        return n;
    endfunction

    initial begin
        mon_reset(0, 0);
        // Reset state
        #23;
        check("rst_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_wr", int'(mem_wr), 0);
        check("rst_addr", int'(mem_addr), 0);
        check("rst_data", int'(out_data), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: clear over a non-zero image, then full-depth scan of zeros
        preload(2'd2);
        mon_reset(0, 0);
        pulse(1'b0, 1'b1, 0);
        wait_done("t1_clear", 1200);
        check("t1_clear_writes", wr_cnt, 1024);
        check("t1_clear_done_cyc", done_rel, 1025);
        check("t1_clear_done_cnt", done_cnt, 1);
        check("t1_clear_noval", first_valid, -1);
        check("t1_clear_wdata", wr_bad, 0);
        check("t1_ram_zero", ram_nonzero(), 0);
        mon_reset(1024, 0);
        pulse(1'b1, 1'b0, 1024);
        wait_done("t1_scan", 1200);
        check("t1_beats", beats, 1024);
        check("t1_data", data_err, 0);
        check("t1_last", last_err, 0);
        check("t1_done_cyc", done_rel, 1027);
        check("t1_first_valid", first_valid, 3);

        // 2: scan 16 of addr[7:0], continuous ready
        preload(2'd1);
        mon_reset(16, 1);
        pulse(1'b1, 1'b0, 16);
        wait_done("t2", 100);
        check("t2_beats", beats, 16);
        check("t2_data", data_err, 0);
        check("t2_last", last_err, 0);
        check("t2_first_valid", first_valid, 3);
        check("t2_gaps", gaps, 0);
        check("t2_done_cyc", done_rel, 19);
        check("t2_busy_after", int'(busy), 0);

        // 3: same scan with ready 1,0,0,1
        mon_reset(16, 1);
        rdy_mode = 1'b1;
        pulse(1'b1, 1'b0, 16);
        wait_done("t3", 200);
        rdy_mode = 1'b0;
        check("t3_beats", beats, 16);
        check("t3_data", data_err, 0);
        check("t3_last", last_err, 0);
        check("t3_stall_stable", stall_err, 0);
        check("t3_done_cnt", done_cnt, 1);

        // 4: len=0, then len=2000 clamped to 1024
        mon_reset(0, 1);
        pulse(1'b1, 1'b0, 0);
        wait_done("t4_len0", 20);
        check("t4_len0_beats", beats, 0);
        check("t4_len0_novalid", first_valid, -1);
        check("t4_len0_done_cyc", done_rel, 1);
        check("t4_len0_busy", int'(busy), 0);
        mon_reset(1024, 1);
        pulse(1'b1, 1'b0, 2000);
        wait_done("t4_clamp", 1200);
        check("t4_clamp_beats", beats, 1024);
        check("t4_clamp_data", data_err, 0);
        check("t4_clamp_last", last_err, 0);
        check("t4_clamp_done_cyc", done_rel, 1027);

        // 5: both starts together -> clear; start_scan mid-clear ignored
        preload(2'd2);
        mon_reset(16, 1);
        pulse(1'b1, 1'b1, 16);
        repeat (100) @(posedge clk);
        #1;
        start_scan = 1'b1;
        len        = 11'd16;
        @(posedge clk); #1;
        start_scan = 1'b0;
        wait_done("t5", 1200);
        repeat (10) @(posedge clk);
        #2;
        check("t5_writes", wr_cnt, 1024);
        check("t5_done_cyc", done_rel, 1025);
        check("t5_done_cnt", done_cnt, 1);
        check("t5_no_beats", beats, 0);
        check("t5_ram_zero", ram_nonzero(), 0);
        check("t5_busy_after", int'(busy), 0);

        // 6: reset at beat 5, then a fresh scan restarts at addr 0
        preload(2'd1);
        mon_reset(16, 1);
        pulse(1'b1, 1'b0, 16);
        for (int n = 0; n < 50; n++) begin
            @(posedge clk); #2;
            if (beats >= 5) break;
        end
        check("t6_beats_before", beats, 5);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", int'(out_valid), 0);
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_wr", int'(mem_wr), 0);
        check("t6_rst_addr", int'(mem_addr), 0);
        check("t6_rst_data", int'(out_data), 0);
        check("t6_rst_last", int'(out_last), 0);
        repeat (5) @(posedge clk);
        #2;
        check("t6_no_done", done_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        mon_reset(4, 1);
        pulse(1'b1, 1'b0, 4);
        wait_done("t6_rescan", 50);
        check("t6_rescan_beats", beats, 4);
        check("t6_rescan_data", data_err, 0);
        check("t6_rescan_last", last_err, 0);
        check("t6_rescan_first", first_valid, 3);
        check("t6_rescan_done_cyc", done_rel, 7);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
